// File: rtl/param_serializer_if.sv
// Parallel-in / serial-out handshake bundle for param_serializer.
// master = word producer and serial consumer; slave = the serializer itself.
interface param_serializer_if #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = $clog2(DATA_W)
);
  logic [DATA_W-1:0] data_i;
  logic [MOD_W-1:0]  data_mod_i;
  logic              data_val_i;
  logic              msb_first_i;
  logic              ser_data_o;
  logic              ser_data_val_o;
  logic              busy_o;

  modport master (
    output data_i, data_mod_i, data_val_i, msb_first_i,
    input  ser_data_o, ser_data_val_o, busy_o
  );

  modport slave (
    input  data_i, data_mod_i, data_val_i, msb_first_i,
    output ser_data_o, ser_data_val_o, busy_o
  );
endinterface

// File: rtl/param_serializer.sv
// Parametrised parallel-to-serial shifter with runtime bit count and MSB/LSB-first order.
// Define PARAM_SERIALIZER_BACK_TO_BACK_EN for zero-gap back-to-back words.
module param_serializer #(
  parameter int DATA_W  = 16,
  parameter int MOD_W   = $clog2(DATA_W),
  parameter int MIN_LEN = 3
) (
  input logic clk_i,
  input logic srst_i,
  param_serializer_if.slave ser_if
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic              msb_first;
  logic [31:0]       len_c;
  logic              in_range;
  logic              accept;

  always_comb begin
    len_c    = (ser_if.data_mod_i == '0) ? 32'(DATA_W) : 32'(ser_if.data_mod_i);
    in_range = (len_c >= 32'(MIN_LEN)) && (len_c <= 32'(DATA_W));
    accept   = ser_if.data_val_i && !ser_if.busy_o && in_range;
  end

  // cnt holds the number of bits still to emit after the one currently on ser_data_o
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state                 <= IDLE;
      shreg                 <= '0;
      cnt                   <= '0;
      msb_first             <= 1'b0;
      ser_if.ser_data_o     <= 1'b0;
      ser_if.ser_data_val_o <= 1'b0;
      ser_if.busy_o         <= 1'b0;
    end else if (accept) begin
      state     <= SHIFT;
      msb_first <= ser_if.msb_first_i;
      cnt       <= CNT_W'(len_c - 32'd1);
      if (ser_if.msb_first_i) begin
        ser_if.ser_data_o <= ser_if.data_i[DATA_W-1];
        shreg             <= {ser_if.data_i[DATA_W-2:0], 1'b0};
      end else begin
        ser_if.ser_data_o <= ser_if.data_i[0];
        shreg             <= {1'b0, ser_if.data_i[DATA_W-1:1]};
      end
      ser_if.ser_data_val_o <= 1'b1;
`ifdef PARAM_SERIALIZER_BACK_TO_BACK_EN
      ser_if.busy_o <= (len_c != 32'd1);
`else
      ser_if.busy_o <= 1'b1;
`endif
    end else if (state == SHIFT && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
      if (msb_first) begin
        ser_if.ser_data_o <= shreg[DATA_W-1];
        shreg             <= {shreg[DATA_W-2:0], 1'b0};
      end else begin
        ser_if.ser_data_o <= shreg[0];
        shreg             <= {1'b0, shreg[DATA_W-1:1]};
      end
      ser_if.ser_data_val_o <= 1'b1;
`ifdef PARAM_SERIALIZER_BACK_TO_BACK_EN
      ser_if.busy_o <= (cnt != CNT_W'(1));
`else
      ser_if.busy_o <= 1'b1;
`endif
    end else begin
      state                 <= IDLE;
      ser_if.ser_data_o     <= 1'b0;
      ser_if.ser_data_val_o <= 1'b0;
      ser_if.busy_o         <= 1'b0;
    end
  end

endmodule
